// File: rtl/jt5205_pkg.sv
// Shared constants for the MSM5205-style ADPCM decoder: step table, index
// adjustment table, FSM state encoding and small saturating helpers.
package jt5205_pkg;

    localparam int IDX_MAX  = 48;
    localparam int SMPL_MAX = 2047;
    localparam int SMPL_MIN = -2048;

    localparam logic [10:0] STEP_TABLE [0:IDX_MAX] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [4:0] ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_CALC   = 2'd2,
        ST_CLAMP  = 2'd3
    } state_t;

    // Step index after applying the magnitude-dependent adjustment, held to 0..IDX_MAX.
    function automatic logic [5:0] idx_next(input logic [5:0] idx, input logic [2:0] mag);
        logic signed [7:0] t;
        t = $signed({2'b00, idx}) + $signed({{3{ADJ[mag][4]}}, ADJ[mag]});
        if (t < 0)
            return 6'd0;
        else if (t > IDX_MAX)
            return 6'(IDX_MAX);
        else
            return t[5:0];
    endfunction

    function automatic logic signed [11:0] sat12(input logic signed [13:0] a);
        if (a > SMPL_MAX)
            return 12'h7FF;
        else if (a < SMPL_MIN)
            return 12'h800;
        else
            return a[11:0];
    endfunction

endpackage

// File: rtl/jt5205_if.sv
// Control/sample bundle between the timing stage and the decoder.
interface jt5205_if;
    logic               cen;
    logic               cen_lo;
    logic [3:0]         din;
    logic               chip_rst;
    logic signed [11:0] sound;
    logic               sample_vld;
    logic               busy;
    logic               ovr;

    modport master (
        output cen, cen_lo, din, chip_rst,
        input  sound, sample_vld, busy, ovr
    );

    modport slave (
        input  cen, cen_lo, din, chip_rst,
        output sound, sample_vld, busy, ovr
    );
endinterface

// File: rtl/jt5205_step_rom.sv
// Step-size ROM with registered read; the address is held to the table range.
module jt5205_step_rom
    import jt5205_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [5:0]  i_idx,
    output logic [10:0] o_step
);

    logic [10:0] r_step;
    logic [5:0]  w_addr;

    assign w_addr = (i_idx > 6'(IDX_MAX)) ? 6'(IDX_MAX) : i_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_step <= '0;
        else if (i_en)
            r_step <= STEP_TABLE[w_addr];
    end

    assign o_step = r_step;

endmodule

// File: rtl/jt5205_decoder.sv
// ADPCM nibble decoder: one nibble per cen_lo strobe walks LOOKUP/CALC/CLAMP
// and produces a saturated 12-bit sample three cen cycles later.
module jt5205_decoder
    import jt5205_pkg::*;
#(
    parameter int OVR_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    jt5205_if.slave     bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start;
    logic               w_strobe;
    logic [3:0]         r_nib;
    logic [5:0]         r_idx;
    logic [10:0]        w_step;
    logic signed [13:0] r_acc;
    logic signed [11:0] r_sound;
    logic               r_vld;
    logic               w_ovr;
    logic [12:0]        w_part [0:3];
    logic [12:0]        w_delta;
    logic signed [13:0] w_sound_ext;
    logic signed [13:0] w_delta_ext;
    logic signed [13:0] w_acc_next;

    assign w_strobe = bus.cen & bus.cen_lo;

    jt5205_step_rom u_step_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (bus.cen & ~bus.chip_rst & (r_state == ST_LOOKUP)),
        .i_idx  (r_idx),
        .o_step (w_step)
    );

    // Partial products: step>>2, step>>1, step selected by nib[0..2]; step>>3 always.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_part
            assign w_part[gi] = r_nib[gi] ? 13'(w_step >> (2 - gi)) : 13'd0;
        end
    endgenerate
    assign w_part[3] = 13'(w_step >> 3);

    assign w_delta     = w_part[0] + w_part[1] + w_part[2] + w_part[3];
    assign w_sound_ext = {{2{r_sound[11]}}, r_sound};
    assign w_delta_ext = {1'b0, w_delta};
    assign w_acc_next  = r_nib[3] ? (w_sound_ext - w_delta_ext) : (w_sound_ext + w_delta_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        if (bus.chip_rst) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_strobe) begin
                        w_state_next = ST_LOOKUP;
                        w_start      = 1'b1;
                    end
                end
                ST_LOOKUP: if (bus.cen) w_state_next = ST_CALC;
                ST_CALC:   if (bus.cen) w_state_next = ST_CLAMP;
                ST_CLAMP:  if (bus.cen) w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_sound <= '0;
            r_vld   <= 1'b0;
        end else if (bus.chip_rst) begin
            r_idx   <= '0;
            r_sound <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_start)
                r_nib <= bus.din;
            if (bus.cen) begin
                if (r_state == ST_CALC)
                    r_acc <= w_acc_next;
                if (r_state == ST_CLAMP) begin
                    r_sound <= sat12(r_acc);
                    r_idx   <= idx_next(r_idx, r_nib[2:0]);
                    r_vld   <= 1'b1;
                end
            end
        end
    end

    // A strobe arriving while a nibble is still in flight is dropped and flagged.
    generate
        if (OVR_EN != 0) begin : g_ovr
            logic r_ovr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_ovr <= 1'b0;
                else if (bus.chip_rst)
                    r_ovr <= 1'b0;
                else if (w_strobe && (r_state != ST_IDLE))
                    r_ovr <= 1'b1;
            end
            assign w_ovr = r_ovr;
        end else begin : g_no_ovr
            assign w_ovr = 1'b0;
        end
    endgenerate

    assign bus.sound      = r_sound;
    assign bus.sample_vld = r_vld;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ovr        = w_ovr;

endmodule

// File: tb/tb_jt5205_decoder.sv
// Randomised bench for jt5205_decoder against a nibble-level ADPCM model.
module tb_jt5205_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jt5205_if bus0 ();
    jt5205_if bus1 ();

    jt5205_decoder #(.OVR_EN(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    jt5205_decoder #(.OVR_EN(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int tbl [0:48] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66,
                       73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
                       253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724,
                       796, 876, 963, 1060, 1166, 1282, 1411, 1552};

    int n_vec = 0;
    int n_err = 0;
    int n_smp = 0;

    // Model: cens remaining until the sample lands (0 = idle), plus decoder history.
    int         m_sound = 0;
    int         m_idx   = 0;
    int         m_left  = 0;
    int         m_ovr   = 0;
    int         m_vld   = 0;
    logic [3:0] m_nib   = 4'h0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit cen, input bit cen_lo, input logic [3:0] din, input bit crst);
        bus0.cen = cen; bus0.cen_lo = cen_lo; bus0.din = din; bus0.chip_rst = crst;
        bus1.cen = cen; bus1.cen_lo = cen_lo; bus1.din = din; bus1.chip_rst = crst;
    endtask

    task automatic model_clear();
        m_sound = 0; m_idx = 0; m_left = 0; m_ovr = 0; m_vld = 0;
    endtask

    task automatic model_decode();
        int step, d, s, mag;
        step = tbl[m_idx];
        mag  = int'(m_nib[2:0]);
        d = step / 8;
        if (m_nib[0]) d += step / 4;
        if (m_nib[1]) d += step / 2;
        if (m_nib[2]) d += step;
        s = m_nib[3] ? m_sound - d : m_sound + d;
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
        m_sound = s;
        m_idx += (mag < 4) ? -1 : 2 * (mag - 3);
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
        m_vld = 1;
    endtask

    task automatic model_edge(input bit cen, input bit cen_lo, input logic [3:0] din, input bit crst);
        m_vld = 0;
        if (crst) begin
            model_clear();
        end else if (cen) begin
            if (cen_lo && m_left == 0) begin
                m_left = 3;
                m_nib  = din;
            end else begin
                if (cen_lo) m_ovr = 1;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) model_decode();
                end
            end
        end
    endtask

    task automatic compare_all();
        check("vld",     bus0.sample_vld, m_vld);
        check("sound",   $signed(bus0.sound), m_sound);
        check("busy",    bus0.busy, (m_left != 0));
        check("ovr",     bus0.ovr, m_ovr);
        check("vld_b",   bus1.sample_vld, m_vld);
        check("sound_b", $signed(bus1.sound), m_sound);
        check("ovr_off", bus1.ovr, 0);
        if (m_vld != 0) begin
            check("idx", u_dut0.r_idx, m_idx);
            n_smp++;
            $display("sample %0d: nib=%h sound=%0d idx=%0d", n_smp, m_nib,
                     $signed(bus0.sound), u_dut0.r_idx);
        end
    endtask

    task automatic cyc(input bit cen, input bit cen_lo, input logic [3:0] din, input bit crst);
        drive(cen, cen_lo, din, crst);
        @(posedge clk);
        model_edge(cen, cen_lo, din, crst);
        @(negedge clk);
        compare_all();
    endtask

    task automatic op(input logic [3:0] din);
        cyc(1'b1, 1'b1, din, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    // Called just after a falling edge; reset is asserted and released before the next rise.
    task automatic async_rst();
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        model_clear();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 4'h0, 1'b0);

        op(4'h7);
        check("r029_sound", $signed(bus0.sound), 30);
        check("r029_idx", u_dut0.r_idx, 8);

        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        op(4'h8);
        check("r030_sound", $signed(bus0.sound), -2);
        check("r030_idx", u_dut0.r_idx, 0);

        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        repeat (60) op(4'h7);
        check("r031_max", $signed(bus0.sound), 2047);
        check("r031_idx", u_dut0.r_idx, 48);
        repeat (60) op(4'hF);
        check("r031_min", $signed(bus0.sound), -2048);

        cyc(1'b1, 1'b1, 4'h7, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        check("r032_busy", bus0.busy, 0);
        check("r032_sound", $signed(bus0.sound), 0);
        repeat (4) cyc(1'b1, 1'b0, 4'h0, 1'b0);

        cyc(1'b1, 1'b1, 4'h3, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b1, 4'h5, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        check("r033_vld", bus0.sample_vld, 1);
        repeat (4) cyc(1'b1, 1'b0, 4'h0, 1'b0);
        check("r033_sticky", bus0.ovr, 1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        check("r033_clear", bus0.ovr, 0);

        cyc(1'b1, 1'b1, 4'h6, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        check("r034_vld", bus0.sample_vld, 1);

        for (int i = 0; i < 3000; i++) begin
            bit         r_cen, r_lo, r_crst;
            logic [3:0] r_din;
            r_crst = ($urandom_range(0, 99) == 0);
            r_cen  = ($urandom_range(0, 3) != 0);
            r_lo   = r_cen && ($urandom_range(0, 4) == 0);
            r_din  = 4'($urandom);
            cyc(r_cen, r_lo, r_din, r_crst);
            if ($urandom_range(0, 499) == 0) async_rst();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
